half_fixed_vector_relu_buffer: RTL
==================================

# half_fixed_vector_relu_buffer

Downstream stage of the half-precision bias-add stage in the neural-network datapath. Consumes the serial stream of FP16 sums (one element per `in_valid`), applies ReLU, buffers a full vector of `LENGTH` elements, then drains it element-by-element to the next layer's vector loader under a valid/ready handshake. Optionally tracks the index of the largest element for classification output layers.

## Interface
- `BITS`, 16, element width; FP16 layout, sign at bit `BITS-1`
- `LENGTH`, 10, elements per vector; must be ≥ 2
- `clk`  in  1  clock; all logic on the rising edge
- `rstn`  in  1  synchronous reset, active-high; the port name matches neighbouring stages
- `in_valid`  in  1  `in_data` is a valid element this cycle; no backpressure upstream
- `in_data`  in  `BITS`  FP16 element from the bias-add stage
- `out_ready`  in  1  consumer accepts `out_data` this cycle
- `out_valid`  out  1  `out_data` holds a buffered element
- `out_data`  out  `BITS`  ReLU'd element at the read pointer
- `out_last`  out  1  current output is element `LENGTH-1`
- `busy`  out  1  high in DRAIN
- `overflow`  out  1  sticky; an input arrived in DRAIN and was dropped
- `argmax_index`  out  `$clog2(LENGTH)`  index of the maximum element (macro only)
- `argmax_valid`  out  1  `argmax_index` is final (macro only)

## Operation
- Storage: `LENGTH` x `BITS` register array; write counter `wr_cnt` and read counter `rd_cnt`, both `$clog2(LENGTH)` bits wide.
- ReLU: if `in_data[BITS-1]` = 1, store 16'h0000. This covers -0, negative values and negative NaN. Otherwise store `in_data` unchanged, including +Inf and positive NaN.
- State FILL (reset state):
  - Each `in_valid` writes ReLU(`in_data`) to `buf[wr_cnt]` and increments `wr_cnt`.
  - When `in_valid` arrives with `wr_cnt` = `LENGTH-1`: write the element, set `wr_cnt` to 0 and `rd_cnt` to 0, and go to DRAIN.
- State DRAIN:
  - `out_valid` = 1 and `out_data` = `buf[rd_cnt]`.
  - A transfer happens on `out_valid && out_ready`; each transfer increments `rd_cnt`.
  - `out_last` = (`rd_cnt` = `LENGTH-1`).
  - A transfer with `out_last` high returns the block to FILL with `rd_cnt` = 0.
- Inputs in DRAIN: `in_valid` in DRAIN is dropped. The buffer is not written and `overflow` is set. `overflow` clears only on reset.
- Output stability: `out_data` and `out_last` stay stable while `out_valid && !out_ready`.
- Reset values: `out_valid` 0, `out_last` 0, `busy` 0, `overflow` 0, `argmax_index` 0, `argmax_valid` 0; state FILL; both counters 0. Buffer contents are not reset. `out_data` may show stale data while `out_valid` = 0.
- Reset mid-operation: a partial fill or partial drain is abandoned. The next `in_valid` after reset writes index 0.

## Timing
- `in_valid` for element `LENGTH-1` sampled at edge N → `out_valid` = 1 in the cycle after edge N.
- With `out_ready` held high, the drain takes exactly `LENGTH` cycles. The first `in_valid` of the next vector is accepted from the cycle after the last transfer.
- `in_valid` in the same cycle as the final drain transfer is still in DRAIN and is dropped, setting `overflow`.
- `out_valid`, `out_last` and `busy` are decoded from registered state and counters only, with no combinational path from `out_ready`.
- `rstn` wins over every simultaneous event.

## Configuration
- Macro: `HALF_RELU_ARGMAX_EN`.
- Defined:
  - During FILL, keep a running max value and its index. The value resets to 0 and the index to 0 at the start of each vector.
  - A new element replaces the max only if ReLU(value) > max as an unsigned `BITS`-bit compare. This is valid because every stored value is non-negative. Ties keep the lower index.
  - `argmax_valid` = 1 throughout DRAIN; `argmax_index` holds its value until the next vector completes.
- Undefined: `argmax_index` and `argmax_valid` ports are absent and no compare logic is built.

## Test plan
- Fill 10 elements 16'h3C00 (1.0) … 16'h4900 (10.0) with `out_ready` = 1 → after 1 cycle, 10 consecutive outputs equal the inputs; `out_last` only on the 10th; then FILL.
- Inputs 16'hBC00 (-1.0), 16'h8000 (-0), 16'hFE00 (negative NaN), 16'h7E00 (positive NaN), 16'h7C00 (+Inf), then 5 × 16'h3800 → outputs 0, 0, 0, 7E00, 7C00, then 3800 ×5.
- Stall: toggle `out_ready` 1/0 every cycle during DRAIN → 10 transfers over 20 cycles; `out_data` held during stalls; `overflow` stays 0.
- Send an 11th `in_valid` while in DRAIN → `overflow` = 1 and the drained data is unchanged. A vector sent after the drain finishes is output correctly; `overflow` stays 1 until `rstn`.
- Assert `rstn` after 5 elements are written, then send 10 new elements → the output is exactly the 10 new elements, with no stale data.
- With `HALF_RELU_ARGMAX_EN`: inputs with 16'h4500 at indices 3 and 7, all others smaller, index 0 = 16'hC800 → `argmax_index` = 3 and `argmax_valid` = 1 during DRAIN.

Source files
------------

// File: rtl/half_fixed_vector_relu_buffer.sv
// ReLU vector buffer: collects LENGTH FP16 elements (negatives forced to zero), then drains them
// under valid/ready. Define HALF_RELU_ARGMAX_EN to add running argmax tracking for classifier outputs.
module half_fixed_vector_relu_buffer #(
  parameter int BITS   = 16,
  parameter int LENGTH = 10
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      in_valid,
  input  logic [BITS-1:0]           in_data,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [BITS-1:0]           out_data,
  output logic                      out_last,
  output logic                      busy,
  output logic                      overflow
`ifdef HALF_RELU_ARGMAX_EN
  ,
  output logic [$clog2(LENGTH)-1:0] argmax_index,
  output logic                      argmax_valid
`endif
);

  localparam int            CW       = $clog2(LENGTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(LENGTH - 1);

  typedef enum logic {
    ST_FILL,
    ST_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
  logic            overflow_q, overflow_d;
  logic [BITS-1:0] buf_q [LENGTH];
  logic [BITS-1:0] relu_data;
  logic            wr_en;

  // Sign bit set covers -0, negative values and negative NaN alike.
  assign relu_data = in_data[BITS-1] ? '0 : in_data;
  assign wr_en     = (state_q == ST_FILL) && in_valid;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_FILL: begin
        if (in_valid) begin
          if (wr_cnt_q == LAST_IDX) begin
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            state_d  = ST_DRAIN;
          end else begin
            wr_cnt_d = wr_cnt_q + CW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (in_valid) overflow_d = 1'b1;
        if (out_ready) begin
          if (rd_cnt_q == LAST_IDX) begin
            rd_cnt_d = '0;
            state_d  = ST_FILL;
          end else begin
            rd_cnt_d = rd_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q    <= ST_FILL;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the element array is deliberately not reset; data is only read after a full fill.
  always_ff @(posedge clk) begin
    if (wr_en && !rstn) buf_q[wr_cnt_q] <= relu_data;
  end

  assign out_valid = (state_q == ST_DRAIN);
  assign busy      = (state_q == ST_DRAIN);
  assign out_last  = (state_q == ST_DRAIN) && (rd_cnt_q == LAST_IDX);
  assign out_data  = buf_q[rd_cnt_q];
  assign overflow  = overflow_q;

`ifdef HALF_RELU_ARGMAX_EN
  logic [BITS-1:0] max_val_q, max_val_d;
  logic [CW-1:0]   max_idx_q, max_idx_d;
  logic [CW-1:0]   arg_idx_q, arg_idx_d;
  logic [BITS-1:0] max_base;
  logic [CW-1:0]   idx_base;

  always_comb begin
    // Element 0 compares against zero so the previous vector's max never leaks in.
    max_base  = (wr_cnt_q == '0) ? '0 : max_val_q;
    idx_base  = (wr_cnt_q == '0) ? '0 : max_idx_q;
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
    arg_idx_d = arg_idx_q;
    if (wr_en) begin
      max_val_d = max_base;
      max_idx_d = idx_base;
      if (relu_data > max_base) begin
        max_val_d = relu_data;
        max_idx_d = wr_cnt_q;
      end
      if (wr_cnt_q == LAST_IDX) arg_idx_d = max_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      max_val_q <= '0;
      max_idx_q <= '0;
      arg_idx_q <= '0;
    end else begin
      max_val_q <= max_val_d;
      max_idx_q <= max_idx_d;
      arg_idx_q <= arg_idx_d;
    end
  end

  assign argmax_index = arg_idx_q;
  assign argmax_valid = (state_q == ST_DRAIN);
`endif

endmodule
